framebuffer_arbiter: RTL and testbench
======================================

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 SHALL have parameter X_MAX, default 159, last valid pixel column.
REQ-002 SHALL have parameter Y_MAX, default 119, last valid pixel row.
REQ-003 SHALL have port CLK  input  1  system clock (100 MHz); all state changes on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset; RESET=0 clears all state immediately.
REQ-005 SHALL have port CPU_REQ  input  1  bus requester wants one frame-buffer access; held until CPU_GNT.
REQ-006 SHALL have port CPU_WE  input  1  1 = pixel write, 0 = pixel read.
REQ-007 SHALL have port CPU_ADDR  input  15  pixel address {Y[6:0], X[7:0]}.
REQ-008 SHALL have port CPU_WDATA  input  1  pixel value for writes.
REQ-009 SHALL have port CPU_GNT  output  1  one-cycle pulse: CPU access issued to frame buffer this cycle.
REQ-010 SHALL have port CPU_RDATA  output  1  read pixel value, valid when CPU_RVALID=1.
REQ-011 SHALL have port CPU_RVALID  output  1  one-cycle pulse: CPU_RDATA valid.
REQ-012 SHALL have port FILL_START  input  1  one-cycle pulse: latch rectangle and begin fill.
REQ-013 SHALL have ports FILL_X0, FILL_X1  input  8  inclusive column bounds.
REQ-014 SHALL have ports FILL_Y0, FILL_Y1  input  7  inclusive row bounds.
REQ-015 SHALL have port FILL_VALUE  input  1  pixel value written across the rectangle.
REQ-016 SHALL have port FILL_ABORT  input  1  stop fill at next edge.
REQ-017 SHALL have port FILL_BUSY  output  1  fill in progress.
REQ-018 SHALL have port FILL_DONE  output  1  one-cycle pulse: fill completed normally.
REQ-019 SHALL have ports FB_ADDR  output  15, FB_DATA_IN  output  1, FB_WE  output  1  frame-buffer port A drive, all registered.
REQ-020 SHALL have port FB_DATA_OUT  input  1  port A read data, one cycle after FB_ADDR.

Function
REQ-021 SHALL implement FSM IDLE/FILL; IDLE->FILL on FILL_START with non-empty rectangle; FILL->IDLE after last pixel or on FILL_ABORT.
REQ-022 SHALL latch bounds and FILL_VALUE on FILL_START; later input changes have no effect on the running fill.
REQ-023 SHALL clip X1 > X_MAX to X_MAX and Y1 > Y_MAX to Y_MAX before use.
REQ-024 SHALL treat X0 > clipped X1 or Y0 > clipped Y1 as empty: zero writes, FILL_DONE pulsed the cycle after FILL_START, FILL_BUSY stays 0.
REQ-025 SHALL scan raster order: X from X0 to X1, then X back to X0 and Y+1; one pixel per granted fill cycle.
REQ-026 SHALL pulse FILL_DONE, clear FILL_BUSY on the same edge that issues pixel (X1,Y1)'s write.
REQ-027 SHALL ignore FILL_START while FILL_BUSY=1.
REQ-028 SHALL on FILL_ABORT in FILL return to IDLE next edge, issue no further fill writes, not pulse FILL_DONE; FILL_ABORT in IDLE has no effect.
REQ-029 SHALL issue at most one frame-buffer access per cycle.
REQ-030 SHALL arbitrate round-robin when CPU_REQ and fill are both pending: grant goes to the requester not granted last; sole requester always granted.
REQ-031 SHALL assert CPU_GNT on the same edge that drives FB_ADDR=CPU_ADDR, FB_WE=CPU_WE, FB_DATA_IN=CPU_WDATA.
REQ-032 SHALL for CPU reads capture FB_DATA_OUT into CPU_RDATA and pulse CPU_RVALID exactly 2 cycles after CPU_GNT.
REQ-033 SHALL drive FB_WE=0 in any cycle with no granted write; FB_ADDR holds its last value.
REQ-034 SHALL not grant CPU in the cycle after its own grant unless CPU_REQ is still high (back-to-back allowed).
REQ-035 SHALL allow FILL_START and a CPU grant in the same cycle; first fill pixel follows arbitration from the next cycle.

Reset
REQ-036 SHALL on RESET=0 set FSM IDLE, FB_WE=0, FB_ADDR=0, FB_DATA_IN=0, CPU_GNT=0, CPU_RVALID=0, CPU_RDATA=0, FILL_BUSY=0, FILL_DONE=0, round-robin pointer = CPU-last (fill wins first tie).
REQ-037 SHALL on reset mid-fill discard the command; pending CPU read produces no CPU_RVALID.

Verification
REQ-038 SHALL pass: fill (2,3)-(4,4) value 1, no CPU -> 6 writes, addrs {3,2},{3,3},{3,4},{4,2},{4,3},{4,4} consecutive cycles, FILL_DONE with last.
REQ-039 SHALL pass: fill 0-159 x 0-119 with CPU_REQ held write -> alternating grants, 19200 fill writes, CPU_GNT every other cycle.
REQ-040 SHALL pass: CPU read addr 0x0105 with FB_DATA_OUT=1 -> CPU_GNT, FB_WE=0, CPU_RVALID=1 & CPU_RDATA=1 two cycles later.
REQ-041 SHALL pass: fill X0=10, X1=5 -> no FB_WE, FILL_DONE next cycle, FILL_BUSY never 1.
REQ-042 SHALL pass: fill X1=200, Y1=127 from (158,118) -> 4 writes ending at (159,119).
REQ-043 SHALL pass: FILL_ABORT after 3 writes, then RESET=0 mid-second fill -> no FILL_DONE, all outputs at reset values immediately.

Source files
------------

// File: rtl/framebuffer_arbiter.sv
// Frame-buffer port arbiter: round-robin sharing of one pixel port between a CPU
// requester and a rectangle fill engine that scans in raster order.
module framebuffer_arbiter #(
    parameter int unsigned X_MAX = 159,
    parameter int unsigned Y_MAX = 119
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [14:0] CPU_ADDR,
    input  logic        CPU_WDATA,
    output logic        CPU_GNT,
    output logic        CPU_RDATA,
    output logic        CPU_RVALID,
    input  logic        FILL_START,
    input  logic [7:0]  FILL_X0,
    input  logic [7:0]  FILL_X1,
    input  logic [6:0]  FILL_Y0,
    input  logic [6:0]  FILL_Y1,
    input  logic        FILL_VALUE,
    input  logic        FILL_ABORT,
    output logic        FILL_BUSY,
    output logic        FILL_DONE,
    output logic [14:0] FB_ADDR,
    output logic        FB_DATA_IN,
    output logic        FB_WE,
    input  logic        FB_DATA_OUT
);

    localparam logic [7:0] X_LAST = 8'(X_MAX);
    localparam logic [6:0] Y_LAST = 7'(Y_MAX);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [7:0]  x0_r;
    logic [7:0]  x1_r;
    logic [7:0]  x_r;
    logic [6:0]  y1_r;
    logic [6:0]  y_r;
    logic        val_r;
    logic        last_cpu_r;

    logic [14:0] fb_addr_r;
    logic        fb_data_r;
    logic        fb_we_r;
    logic        cpu_gnt_r;
    logic        cpu_rvalid_r;
    logic        cpu_rdata_r;
    logic        fill_busy_r;
    logic        fill_done_r;
    logic        rd_pend1_r;
    logic        rd_pend2_r;

    logic [7:0]  x1_clip_s;
    logic [6:0]  y1_clip_s;
    logic        empty_s;
    logic        start_ok_s;
    logic        start_empty_s;
    logic        fill_req_s;
    logic        gnt_cpu_s;
    logic        gnt_fill_s;
    logic        last_pix_s;

    // Command decode, round-robin arbitration and next-state logic
    always_comb begin
        x1_clip_s     = (FILL_X1 > X_LAST) ? X_LAST : FILL_X1;
        y1_clip_s     = (FILL_Y1 > Y_LAST) ? Y_LAST : FILL_Y1;
        empty_s       = (FILL_X0 > x1_clip_s) || (FILL_Y0 > y1_clip_s);
        start_ok_s    = (state_r == ST_IDLE) && FILL_START && !empty_s;
        start_empty_s = (state_r == ST_IDLE) && FILL_START && empty_s;
        // An abort withdraws the fill from arbitration on the very edge it is seen.
        fill_req_s    = (state_r == ST_FILL) && !FILL_ABORT;
        last_pix_s    = (x_r == x1_r) && (y_r == y1_r);

        if (CPU_REQ && fill_req_s) begin
            gnt_cpu_s  = !last_cpu_r;
            gnt_fill_s = last_cpu_r;
        end else begin
            gnt_cpu_s  = CPU_REQ;
            gnt_fill_s = fill_req_s;
        end

        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (FILL_ABORT) begin
                    state_nxt_s = ST_IDLE;
                end else if (gnt_fill_s && last_pix_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fill rectangle latch and raster scan position
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            x0_r  <= 8'd0;
            x1_r  <= 8'd0;
            x_r   <= 8'd0;
            y1_r  <= 7'd0;
            y_r   <= 7'd0;
            val_r <= 1'b0;
        end else if (start_ok_s) begin
            x0_r  <= FILL_X0;
            x1_r  <= x1_clip_s;
            x_r   <= FILL_X0;
            y1_r  <= y1_clip_s;
            y_r   <= FILL_Y0;
            val_r <= FILL_VALUE;
        end else if (gnt_fill_s) begin
            if (x_r == x1_r) begin
                x_r <= x0_r;
                y_r <= y_r + 7'd1;
            end else begin
                x_r <= x_r + 8'd1;
            end
        end
    end

    // Frame-buffer port drive, grant/status pulses and round-robin pointer
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fb_addr_r   <= 15'd0;
            fb_data_r   <= 1'b0;
            fb_we_r     <= 1'b0;
            cpu_gnt_r   <= 1'b0;
            fill_busy_r <= 1'b0;
            fill_done_r <= 1'b0;
            last_cpu_r  <= 1'b1;
        end else begin
            if (gnt_cpu_s) begin
                fb_addr_r <= CPU_ADDR;
                fb_data_r <= CPU_WDATA;
                fb_we_r   <= CPU_WE;
            end else if (gnt_fill_s) begin
                fb_addr_r <= {y_r, x_r};
                fb_data_r <= val_r;
                fb_we_r   <= 1'b1;
            end else begin
                fb_we_r   <= 1'b0;
            end
            if (gnt_cpu_s) begin
                last_cpu_r <= 1'b1;
            end else if (gnt_fill_s) begin
                last_cpu_r <= 1'b0;
            end
            cpu_gnt_r   <= gnt_cpu_s;
            fill_busy_r <= (state_nxt_s == ST_FILL);
            fill_done_r <= start_empty_s || (gnt_fill_s && last_pix_s);
        end
    end

    // CPU read return: RAM answers one cycle after the address, captured one cycle later
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_pend1_r   <= 1'b0;
            rd_pend2_r   <= 1'b0;
            cpu_rvalid_r <= 1'b0;
            cpu_rdata_r  <= 1'b0;
        end else begin
            rd_pend1_r   <= gnt_cpu_s && !CPU_WE;
            rd_pend2_r   <= rd_pend1_r;
            cpu_rvalid_r <= rd_pend2_r;
            if (rd_pend2_r) begin
                cpu_rdata_r <= FB_DATA_OUT;
            end
        end
    end

    assign FB_ADDR    = fb_addr_r;
    assign FB_DATA_IN = fb_data_r;
    assign FB_WE      = fb_we_r;
    assign CPU_GNT    = cpu_gnt_r;
    assign CPU_RVALID = cpu_rvalid_r;
    assign CPU_RDATA  = cpu_rdata_r;
    assign FILL_BUSY  = fill_busy_r;
    assign FILL_DONE  = fill_done_r;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter: frame-buffer writes and CPU read data are
// checked against scoreboard queues filled as each stimulus step is driven.
module tb_framebuffer_arbiter;

    logic        CLK;
    logic        RESET;
    logic        CPU_REQ;
    logic        CPU_WE;
    logic [14:0] CPU_ADDR;
    logic        CPU_WDATA;
    logic        CPU_GNT;
    logic        CPU_RDATA;
    logic        CPU_RVALID;
    logic        FILL_START;
    logic [7:0]  FILL_X0;
    logic [7:0]  FILL_X1;
    logic [6:0]  FILL_Y0;
    logic [6:0]  FILL_Y1;
    logic        FILL_VALUE;
    logic        FILL_ABORT;
    logic        FILL_BUSY;
    logic        FILL_DONE;
    logic [14:0] FB_ADDR;
    logic        FB_DATA_IN;
    logic        FB_WE;
    logic        FB_DATA_OUT;

    framebuffer_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_GNT(CPU_GNT), .CPU_RDATA(CPU_RDATA), .CPU_RVALID(CPU_RVALID),
        .FILL_START(FILL_START), .FILL_X0(FILL_X0), .FILL_X1(FILL_X1),
        .FILL_Y0(FILL_Y0), .FILL_Y1(FILL_Y1), .FILL_VALUE(FILL_VALUE),
        .FILL_ABORT(FILL_ABORT), .FILL_BUSY(FILL_BUSY), .FILL_DONE(FILL_DONE),
        .FB_ADDR(FB_ADDR), .FB_DATA_IN(FB_DATA_IN), .FB_WE(FB_WE), .FB_DATA_OUT(FB_DATA_OUT)
    );

    logic        mem [0:32767];
    logic [15:0] wq[$];
    logic        rq[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc, wr_cnt, gnt_cnt, done_cnt;
    logic        busy_seen;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous-read single-bit frame buffer model
    always @(posedge CLK) begin
        FB_DATA_OUT <= mem[FB_ADDR];
        if (FB_WE) mem[FB_ADDR] <= FB_DATA_IN;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge and drain the scoreboards
    task automatic tick();
        logic [15:0] e;
        logic        r;
        @(posedge CLK);
        #1;
        cyc++;
        if (FB_WE) begin
            wr_cnt++;
            chk("fb_write_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                chk("fb_write", 32'({FB_ADDR, FB_DATA_IN}), 32'(e));
            end
        end
        if (CPU_RVALID) begin
            chk("rvalid_expected", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
                r = rq.pop_front();
                chk("cpu_rdata", 32'(CPU_RDATA), 32'(r));
            end
        end
        if (CPU_GNT) gnt_cnt++;
        if (FILL_DONE) done_cnt++;
        if (FILL_BUSY) busy_seen = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        tick();
        while (!FILL_DONE && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(FILL_DONE), 32'd1);
    endtask

    task automatic drive_fill(input logic [7:0] x0, input logic [7:0] x1,
                              input logic [6:0] y0, input logic [6:0] y1, input logic v);
        FILL_START = 1'b1;
        FILL_X0 = x0; FILL_X1 = x1; FILL_Y0 = y0; FILL_Y1 = y1; FILL_VALUE = v;
    endtask

    task automatic push_wr(input int x, input int y, input logic v);
        wq.push_back({7'(y), 8'(x), v});
    endtask

    task automatic clear_counts();
        cyc = 0; wr_cnt = 0; gnt_cnt = 0; done_cnt = 0; busy_seen = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},    32'(FB_WE), 32'd0);
        chk({tag, "_addr"},  32'(FB_ADDR), 32'd0);
        chk({tag, "_din"},   32'(FB_DATA_IN), 32'd0);
        chk({tag, "_gnt"},   32'(CPU_GNT), 32'd0);
        chk({tag, "_rv"},    32'(CPU_RVALID), 32'd0);
        chk({tag, "_rd"},    32'(CPU_RDATA), 32'd0);
        chk({tag, "_busy"},  32'(FILL_BUSY), 32'd0);
        chk({tag, "_done"},  32'(FILL_DONE), 32'd0);
    endtask

    initial begin
        RESET = 1'b0;
        CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = 15'd0; CPU_WDATA = 1'b0;
        FILL_START = 1'b0; FILL_X0 = 8'd0; FILL_X1 = 8'd0; FILL_Y0 = 7'd0; FILL_Y1 = 7'd0;
        FILL_VALUE = 1'b0; FILL_ABORT = 1'b0;
        clear_counts();
        #22;
        chk_reset_outputs("reset");
        tick();
        RESET = 1'b1;
        tick();

        // Small fill (2,3)-(4,4), inputs scrambled after start, restart ignored while busy
        clear_counts();
        for (int y = 3; y <= 4; y++)
            for (int x = 2; x <= 4; x++) push_wr(x, y, 1'b1);
        drive_fill(8'd2, 8'd4, 7'd3, 7'd4, 1'b1);
        tick();
        chk("small_busy_after_start", 32'(FILL_BUSY), 32'd1);
        chk("small_no_write_at_start", 32'(FB_WE), 32'd0);
        FILL_START = 1'b0;
        FILL_X0 = 8'd0; FILL_X1 = 8'd100; FILL_Y0 = 7'd0; FILL_Y1 = 7'd100; FILL_VALUE = 1'b0;
        tick();
        FILL_START = 1'b1;
        FILL_X0 = 8'd0; FILL_X1 = 8'd0; FILL_Y0 = 7'd0; FILL_Y1 = 7'd0;
        tick();
        FILL_START = 1'b0;
        wait_done("small_done", 20);
        chk("small_last_addr", 32'(FB_ADDR), 32'({7'd4, 8'd4}));
        chk("small_last_we", 32'(FB_WE), 32'd1);
        chk("small_busy_cleared", 32'(FILL_BUSY), 32'd0);
        chk("small_write_count", 32'(wr_cnt), 32'd6);
        chk("small_cycles", 32'(cyc), 32'd7);
        tick();
        tick();
        chk("small_queue_empty", 32'(wq.size()), 32'd0);
        chk("small_done_count", 32'(done_cnt), 32'd1);

        // CPU write then reads of 0x0105 and of a filled pixel
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 15'h0105; CPU_WDATA = 1'b1;
        wq.push_back({15'h0105, 1'b1});
        tick();
        chk("cpuw_gnt", 32'(CPU_GNT), 32'd1);
        CPU_REQ = 1'b0;
        tick();
        chk("cpuw_no_regrant", 32'(CPU_GNT), 32'd0);
        chk("cpuw_we_dropped", 32'(FB_WE), 32'd0);
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 15'h0105;
        rq.push_back(1'b1);
        tick();
        chk("cpur_gnt", 32'(CPU_GNT), 32'd1);
        chk("cpur_we", 32'(FB_WE), 32'd0);
        chk("cpur_addr", 32'(FB_ADDR), 32'h0105);
        CPU_ADDR = 15'h0302;
        rq.push_back(1'b1);
        tick();
        chk("cpur2_gnt_back_to_back", 32'(CPU_GNT), 32'd1);
        chk("cpur_rvalid_early", 32'(CPU_RVALID), 32'd0);
        CPU_REQ = 1'b0;
        tick();
        chk("cpur_rvalid", 32'(CPU_RVALID), 32'd1);
        tick();
        chk("cpur2_rvalid", 32'(CPU_RVALID), 32'd1);
        tick();
        chk("cpur_rvalid_single", 32'(CPU_RVALID), 32'd0);
        chk("cpur_queue_empty", 32'(rq.size()), 32'd0);

        // Empty rectangle: X0 > X1
        clear_counts();
        drive_fill(8'd10, 8'd5, 7'd0, 7'd0, 1'b1);
        tick();
        FILL_START = 1'b0;
        chk("empty_done_next", 32'(FILL_DONE), 32'd1);
        chk("empty_busy", 32'(FILL_BUSY), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("empty_writes", 32'(wr_cnt), 32'd0);
        chk("empty_busy_never", 32'(busy_seen), 32'd0);
        chk("empty_done_once", 32'(done_cnt), 32'd1);

        // Clipped rectangle from (158,118) with X1=200, Y1=127
        clear_counts();
        push_wr(158, 118, 1'b1); push_wr(159, 118, 1'b1);
        push_wr(158, 119, 1'b1); push_wr(159, 119, 1'b1);
        drive_fill(8'd158, 8'd200, 7'd118, 7'd127, 1'b1);
        tick();
        FILL_START = 1'b0;
        wait_done("clip_done", 20);
        chk("clip_last_addr", 32'(FB_ADDR), 32'({7'd119, 8'd159}));
        chk("clip_writes", 32'(wr_cnt), 32'd4);
        tick();
        chk("clip_queue_empty", 32'(wq.size()), 32'd0);

        // Full screen with CPU write request held: CPU first, then strict alternation
        clear_counts();
        CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 15'h7FFF; CPU_WDATA = 1'b0;
        wq.push_back({15'h7FFF, 1'b0});
        for (int y = 0; y <= 119; y++)
            for (int x = 0; x <= 159; x++) begin
                push_wr(x, y, 1'b1);
                if (!(x == 159 && y == 119)) wq.push_back({15'h7FFF, 1'b0});
            end
        drive_fill(8'd0, 8'd159, 7'd0, 7'd119, 1'b1);
        tick();
        FILL_START = 1'b0;
        wait_done("full_done", 40000);
        CPU_REQ = 1'b0;
        chk("full_cycles", 32'(cyc), 32'd38400);
        chk("full_writes", 32'(wr_cnt), 32'd38400);
        chk("full_cpu_grants", 32'(gnt_cnt), 32'd19200);
        chk("full_last_addr", 32'(FB_ADDR), 32'({7'd119, 8'd159}));
        tick();
        chk("full_idle_we", 32'(FB_WE), 32'd0);
        chk("full_queue_empty", 32'(wq.size()), 32'd0);

        // Abort after three writes
        clear_counts();
        push_wr(0, 0, 1'b0); push_wr(1, 0, 1'b0); push_wr(2, 0, 1'b0);
        drive_fill(8'd0, 8'd9, 7'd0, 7'd0, 1'b0);
        tick();
        FILL_START = 1'b0;
        tick(); tick(); tick();
        chk("abort_pre_writes", 32'(wr_cnt), 32'd3);
        FILL_ABORT = 1'b1;
        tick();
        FILL_ABORT = 1'b0;
        chk("abort_no_write", 32'(FB_WE), 32'd0);
        chk("abort_busy", 32'(FILL_BUSY), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("abort_writes", 32'(wr_cnt), 32'd3);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Second fill, CPU read granted, then reset mid-fill
        clear_counts();
        push_wr(0, 5, 1'b1);
        drive_fill(8'd0, 8'd9, 7'd5, 7'd5, 1'b1);
        tick();
        FILL_START = 1'b0;
        tick();
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 15'h0105;
        tick();
        chk("rst_cpu_gnt", 32'(CPU_GNT), 32'd1);
        CPU_REQ = 1'b0;
        RESET = 1'b0;
        #1;
        chk_reset_outputs("midfill_reset");
        tick(); tick();
        RESET = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rst_writes", 32'(wr_cnt), 32'd1);
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        chk("rst_fill_discarded", 32'(busy_seen), 32'd0);
        chk("rst_queue_empty", 32'(wq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
